seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
Receive-side counterpart of the stopwatch's multiplexed seven-segment driver. It samples the active-low seg/an bus, waits for each anode phase to settle, decodes the lit segment pattern back to a 4-bit hex value, and latches it per digit position. It flags a completed frame and reports protocol errors. It sits between the display outputs and on-board self-check logic or a bench scoreboard.

Parameters:
SETTLE_CYCLES, 4, number of consecutive identical {seg,an} samples required before a capture (legal range 2..255)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
seg  input  7  segment lines, active-low, seg[0]=a ... seg[6]=g
an  input  4  anode enables, active-low, an[i] selects digit i
clr_err  input  1  synchronous clear of sticky error flags
digits  output  16  captured hex values, digits[4i+3:4i] = digit i
digit_valid  output  4  bit i = digit i holds a decoded value (0 = blank)
frame_valid  output  1  one-cycle pulse when all 4 positions captured since last pulse
bad_pattern  output  1  sticky: unmatched non-blank segment pattern captured
multi_anode  output  1  sticky: settled sample had >1 anode active

Behaviour:
- Reset (rst_n=0 at a clk edge): digits=0, digit_valid=0, frame_valid=0, bad_pattern=0, multi_anode=0. Input register, stability counter and seen-mask also clear. Reset is honoured mid-capture, and the partial frame is discarded.
- Input stage: seg/an are registered once and inverted internally to active-high (s, a).
- Stability counter: compares each registered sample with the previous one. If equal, the counter increments and saturates at SETTLE_CYCLES. If different, it resets to 0.
- Capture fires only on the cycle the counter transitions to SETTLE_CYCLES-1, so there is exactly one capture per stable window.
- Timing: if the input is stable from edge t, the capture decision is at t+SETTLE_CYCLES and outputs update at edge t+SETTLE_CYCLES+1.
- Capture actions, by number of active anodes:
  - 0 anodes: no action.
  - Exactly 1 anode (index i), s=0 (blank): digit_valid[i]<=0, digits nibble unchanged, seen[i]<=1.
  - Exactly 1 anode, s matches the table: nibble i <= value, digit_valid[i]<=1, seen[i]<=1.
  - Exactly 1 anode, s unmatched: bad_pattern<=1. Nibble, valid and seen are unchanged.
  - More than 1 anode: multi_anode<=1, no digit update.
- Decode table (active-high gfedcba hex -> value):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9
  - 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
- Frame tracking:
  - When the seen mask becomes 1111, frame_valid pulses high for exactly the following cycle and seen clears to 0000.
  - Re-capturing an already-seen position before the frame completes overwrites the nibble and leaves seen set.
- Error flags:
  - clr_err clears bad_pattern and multi_anode on the next edge.
  - If clr_err coincides with a new error capture, the flag ends set (error wins).
  - Flags never affect the decode path.
- Glitches: any change shorter than SETTLE_CYCLES samples produces no capture. After the glitch, the counter restarts.
- Sustained stable input: no repeated captures; the counter saturates.

Test Plan:
1. Reset then idle (seg=7F, an=F), 50 cycles -> digits=0000, digit_valid=0, all flags 0, no frame_valid.
2. Scan an=E,D,B,7 with seg for 1,2,3,4 (active-low 79,24,30,19), 10 cycles each -> digits=16'h4321, digit_valid=F. frame_valid pulses once, 6 cycles after the an=7 phase starts (SETTLE_CYCLES=4).
3. During a stable an=E phase showing "8", inject 2-cycle seg=40 ("0") then return -> digit 0 stays 8, no extra capture, no error.
4. an=E with seg=active-low of 0x49 (unmatched) for 10 cycles -> bad_pattern=1, digit 0 unchanged. Pulse clr_err -> bad_pattern=0 next edge. Repeat with clr_err asserted on the capture cycle -> bad_pattern=1.
5. an=C (two digits) with seg stable 10 cycles -> multi_anode=1, digits unchanged, no frame_valid. Then drive an=E with seg blank (7F) -> digit_valid[0]=0.
6. Deassert rst_n after capturing 3 of 4 digits, then scan only digit 3 -> no frame_valid. Full rescan -> exactly one frame_valid.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low seven-segment/anode bus.
// Waits for each anode phase to settle, decodes the digit, and tracks whole frames.
module seg_scan_decoder #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  input  logic        clr_err,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic        frame_valid,
  output logic        bad_pattern,
  output logic        multi_anode
);

  localparam logic [7:0] CNT_SAT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] CNT_CAP = 8'(SETTLE_CYCLES - 1);

  // Returns {hit, value}; hit=0 for any pattern outside the hex font.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = 5'b0;
    endcase
    return r;
  endfunction

  // Samples are stored active-high as {a, s}, so the cleared state reads as idle.
  logic [10:0] samp_q, samp_d;
  logic [10:0] prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  seen_q, seen_d;
  logic        frame_q, frame_d;
  logic        bad_q, bad_d;
  logic        multi_q, multi_d;

  logic        capture;
  logic [3:0]  cap_a;
  logic [6:0]  cap_s;
  logic [4:0]  dec;
  logic        one_hot;
  logic        multi_hot;
  logic [3:0]  seen_hit;
  logic        bad_set;
  logic        multi_set;

  always_comb begin
    samp_d = {~an, ~seg};
    prev_d = samp_q;

    if (samp_q == prev_q) begin
      cnt_d = (cnt_q == CNT_SAT) ? CNT_SAT : cnt_q + 8'd1;
    end else begin
      cnt_d = '0;
    end

    // The counter sits at CNT_CAP for exactly one cycle per stable window;
    // prev_q holds a sample that is guaranteed to be inside that window.
    capture   = (cnt_q == CNT_CAP);
    cap_a     = prev_q[10:7];
    cap_s     = prev_q[6:0];
    dec       = decode_seg(cap_s);
    one_hot   = (cap_a != 4'd0) && ((cap_a & (cap_a - 4'd1)) == 4'd0);
    multi_hot = (cap_a != 4'd0) && !one_hot;

    digits_d  = digits_q;
    valid_d   = valid_q;
    seen_hit  = 4'd0;
    bad_set   = 1'b0;
    multi_set = 1'b0;

    if (capture && one_hot) begin
      if (cap_s == 7'd0) begin
        valid_d  = valid_q & ~cap_a;
        seen_hit = cap_a;
      end else if (dec[4]) begin
        for (int i = 0; i < 4; i++) begin
          if (cap_a[i]) digits_d[4*i +: 4] = dec[3:0];
        end
        valid_d  = valid_q | cap_a;
        seen_hit = cap_a;
      end else begin
        bad_set = 1'b1;
      end
    end
    if (capture && multi_hot) multi_set = 1'b1;

    frame_d = (seen_q == 4'hF);
    seen_d  = ((seen_q == 4'hF) ? 4'd0 : seen_q) | seen_hit;
    bad_d   = (bad_q & ~clr_err) | bad_set;
    multi_d = (multi_q & ~clr_err) | multi_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      digits_q <= '0;
      valid_q  <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      bad_q    <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      samp_q   <= samp_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      bad_q    <= bad_d;
      multi_q  <= multi_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_valid = frame_q;
  assign bad_pattern = bad_q;
  assign multi_anode = multi_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scenarios plus random phases, every cycle
// compared against a run-length/event-queue reference model.
module tb_seg_scan_decoder;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        clr_err;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_valid;
  logic        bad_pattern;
  logic        multi_anode;

  seg_scan_decoder #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .an(an), .clr_err(clr_err),
    .digits(digits), .digit_valid(digit_valid), .frame_valid(frame_valid),
    .bad_pattern(bad_pattern), .multi_anode(multi_anode)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frame_cnt = 0;
  int last_frame_cyc = 0;

  // Active-high gfedcba font, indexed by hex value.
  logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [3:0]  m_dig [4];
  logic [3:0]  m_valid, m_seen;
  logic        m_frame, m_bad, m_multi;
  logic [10:0] m_last;
  int          m_run;
  logic        p1_v, p2_v;
  logic [10:0] p1_d, p2_d;

  function automatic logic [6:0] al(input int n);
    return ~pat[n];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A sample that completes a run of SETTLE identical samples becomes a capture
  // event whose effect is visible two edges later.
  task automatic model_edge();
    logic [3:0] a;
    logic [6:0] s;
    logic [10:0] v;
    logic nb, nm;
    int n, idx, hit;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 4'h0;
      m_valid = 4'h0; m_seen = 4'h0; m_frame = 1'b0; m_bad = 1'b0; m_multi = 1'b0;
      m_last = 11'd0; m_run = 2; p1_v = 1'b0; p2_v = 1'b0; p1_d = '0; p2_d = '0;
      return;
    end
    m_frame = (m_seen == 4'hF);
    if (m_seen == 4'hF) m_seen = 4'h0;
    nb = 1'b0; nm = 1'b0;
    if (p2_v) begin
      a = p2_d[10:7]; s = p2_d[6:0]; n = $countones(a);
      if (n > 1) nm = 1'b1;
      else if (n == 1) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (a[i]) idx = i;
        if (s == 7'd0) begin
          m_valid[idx] = 1'b0; m_seen[idx] = 1'b1;
        end else begin
          hit = -1;
          for (int k = 0; k < 16; k++) if (pat[k] == s) hit = k;
          if (hit >= 0) begin
            m_dig[idx] = 4'(hit); m_valid[idx] = 1'b1; m_seen[idx] = 1'b1;
          end else nb = 1'b1;
        end
      end
    end
    m_bad   = (m_bad && !clr_err) || nb;
    m_multi = (m_multi && !clr_err) || nm;
    p2_v = p1_v; p2_d = p1_d;
    v = {~an, ~seg};
    if (v == m_last) begin
      if (m_run <= SETTLE) m_run++;
    end else begin
      m_last = v; m_run = 1;
    end
    p1_v = (m_run == SETTLE);
    p1_d = v;
  endtask

  task automatic step(input logic [6:0] s_al, input logic [3:0] a_al, input logic clr);
    seg = s_al; an = a_al; clr_err = clr;
    @(posedge clk);
    model_edge();
    #1;
    chk("digits", digits, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    chk("digit_valid", {12'd0, digit_valid}, {12'd0, m_valid});
    chk("frame_valid", {15'd0, frame_valid}, {15'd0, m_frame});
    chk("bad_pattern", {15'd0, bad_pattern}, {15'd0, m_bad});
    chk("multi_anode", {15'd0, multi_anode}, {15'd0, m_multi});
    cyc++;
    if (frame_valid) begin
      frame_cnt++;
      last_frame_cyc = cyc;
    end
  endtask

  task automatic hold(input logic [6:0] s_al, input logic [3:0] a_al, input int n);
    for (int i = 0; i < n; i++) step(s_al, a_al, 1'b0);
  endtask

  initial begin
    int start;
    int len;
    int sel;
    logic [3:0] ra;
    logic [6:0] rs;
    logic [15:0] saved;

    rst_n = 1'b0; seg = 7'h7F; an = 4'hF; clr_err = 1'b0;
    hold(7'h7F, 4'hF, 3);
    rst_n = 1'b1;

    // Idle after reset
    hold(7'h7F, 4'hF, 50);
    chk("t1_digits", digits, 16'h0000);
    chk("t1_valid", {12'd0, digit_valid}, 16'h0000);
    chk("t1_flags", {14'd0, bad_pattern, multi_anode}, 16'h0000);
    chk("t1_frames", 16'(frame_cnt), 16'd0);

    // Full scan of 1,2,3,4
    frame_cnt = 0;
    hold(al(1), 4'hE, 10);
    hold(al(2), 4'hD, 10);
    hold(al(3), 4'hB, 10);
    start = cyc;
    hold(al(4), 4'h7, 10);
    chk("t2_digits", digits, 16'h4321);
    chk("t2_valid", {12'd0, digit_valid}, 16'h000F);
    chk("t2_frames", 16'(frame_cnt), 16'd1);
    chk("t2_frame_ofs", 16'(last_frame_cyc - start - 1), 16'd6);

    // Short glitch inside a stable "8" phase
    hold(al(8), 4'hE, 10);
    hold(al(0), 4'hE, 2);
    hold(al(8), 4'hE, 10);
    chk("t3_digit0", {12'd0, digits[3:0]}, 16'h0008);
    chk("t3_flags", {14'd0, bad_pattern, multi_anode}, 16'h0000);

    // Unmatched pattern, clear, then clear colliding with a new error
    hold(7'h36, 4'hE, 10);
    chk("t4_bad_set", {15'd0, bad_pattern}, 16'd1);
    chk("t4_digit0", {12'd0, digits[3:0]}, 16'h0008);
    step(7'h36, 4'hE, 1'b1);
    chk("t4_bad_clr", {15'd0, bad_pattern}, 16'd0);
    hold(7'h7F, 4'hF, 5);
    for (int i = 0; i < 10; i++) begin
      step(7'h36, 4'hE, i == SETTLE + 1);
      if (i == SETTLE + 1) chk("t4_err_wins", {15'd0, bad_pattern}, 16'd1);
    end

    // Two anodes at once, then a blank digit
    step(7'h7F, 4'hF, 1'b1);
    saved = digits;
    frame_cnt = 0;
    hold(al(5), 4'hC, 10);
    chk("t5_multi", {15'd0, multi_anode}, 16'd1);
    chk("t5_digits", digits, saved);
    chk("t5_frames", 16'(frame_cnt), 16'd0);
    hold(7'h7F, 4'hE, 10);
    chk("t5_blank", {15'd0, digit_valid[0]}, 16'd0);

    // Reset mid-frame discards the partial frame
    step(7'h7F, 4'hF, 1'b1);
    hold(al(5), 4'hE, 10);
    hold(al(6), 4'hD, 10);
    hold(al(7), 4'hB, 10);
    rst_n = 1'b0;
    hold(al(7), 4'hB, 2);
    rst_n = 1'b1;
    chk("t6_rst_digits", digits, 16'h0000);
    chk("t6_rst_valid", {12'd0, digit_valid}, 16'h0000);
    frame_cnt = 0;
    hold(al(9), 4'h7, 10);
    chk("t6_no_frame", 16'(frame_cnt), 16'd0);
    hold(al(1), 4'hE, 10);
    hold(al(2), 4'hD, 10);
    hold(al(3), 4'hB, 10);
    hold(al(4), 4'h7, 10);
    chk("t6_one_frame", 16'(frame_cnt), 16'd1);
    chk("t6_digits", digits, 16'h4321);

    // Random phases
    for (int p = 0; p < 150; p++) begin
      len = $urandom_range(1, 10);
      sel = $urandom_range(0, 5);
      if (sel < 4) ra = ~(4'd1 << sel);
      else if (sel == 4) ra = 4'hF;
      else ra = 4'($urandom);
      sel = $urandom_range(0, 19);
      if (sel < 16) rs = al(sel);
      else if (sel == 16) rs = 7'h7F;
      else rs = 7'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        step(rs, ra, 1'b0);
        rst_n = 1'b1;
      end
      for (int i = 0; i < len; i++) step(rs, ra, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
